// File: rtl/uart_rx_push.sv
// UART 8N1 receiver feeding the receive FIFO directly.
// Oversamples rx with the system clock, deserialises LSB-first frames and
// hands each good byte to the FIFO as a single-cycle push with data valid
// in the same cycle.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   rx         asynchronous serial input, idles high
//   full       FIFO full, looked at only on the stop-bit sample cycle
//   o_data     last good byte; valid whenever push is high
//   push       one-cycle FIFO write strobe
//   frame_err  one-cycle pulse, stop bit sampled low
//   overrun    one-cycle pulse, good byte completed while full
//   busy       high while a frame is being received (START/DATA/STOP)
module uart_rx_push #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  full,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  push,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int unsigned CW = (CLKS_PER_BIT <= 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = (DATA_WIDTH <= 2) ? 1 : $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF     = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                  state, state_d;
  logic [1:0]              sync;
  logic                    rx_s;
  logic [CW-1:0]           cnt, cnt_d;
  logic [BW-1:0]           idx, idx_d;
  logic [DATA_WIDTH-1:0]   shreg, shreg_d;
  logic [DATA_WIDTH-1:0]   data_d;
  logic                    push_d, frame_err_d, overrun_d;

  assign rx_s = sync[1];
  assign busy = (state == START) || (state == DATA) || (state == STOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= '1;
      state     <= WAIT_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      o_data    <= '0;
      push      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sync      <= {sync[0], rx};
      state     <= state_d;
      cnt       <= cnt_d;
      idx       <= idx_d;
      shreg     <= shreg_d;
      o_data    <= data_d;
      push      <= push_d;
      frame_err <= frame_err_d;
      overrun   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt + CW'(1);
    idx_d       = idx;
    shreg_d     = shreg;
    data_d      = o_data;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    case (state)
      // Line must be seen high for a full bit time before a start edge counts.
      WAIT_IDLE: begin
        if (!rx_s) begin
          cnt_d = '0;
        end else if (cnt == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end

      // Re-check the start bit at its middle; a high level there is a glitch.
      START: begin
        if (cnt == HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end

      // Samples land mid-bit because START already consumed half a bit.
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = DATA_WIDTH'({rx_s, shreg} >> 1);
          if (idx == IDX_LAST) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx + BW'(1);
          end
        end
      end

      // Leaving at mid-stop lets a start edge right after the stop bit be caught.
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
            if (full) begin
              overrun_d = 1'b1;
            end else begin
              push_d = 1'b1;
              data_d = shreg;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = WAIT_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_push.sv
module tb_uart_rx_push;

  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       full = 1'b0;
  logic [7:0] o_data;
  logic       push, frame_err, overrun, busy;

  int unsigned cyc = 0;
  int total = 0;
  int bad = 0;

  // event bookkeeping, filled at the falling edge
  int unsigned push_cnt = 0, fe_cnt = 0, ov_cnt = 0, busy_cnt = 0, viol = 0;
  int unsigned last_push_cyc = 0, prev_push_cyc = 0, last_fe_cyc = 0, last_ov_cyc = 0;
  logic [7:0]  last_push_data = '0, prev_push_data = '0;
  bit          prev_any = 1'b0;

  uart_rx_push #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .rx(rx), .full(full), .o_data(o_data),
    .push(push), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    bit any;
    any = (push === 1'b1) || (frame_err === 1'b1) || (overrun === 1'b1);
    if (push === 1'b1) begin
      push_cnt       <= push_cnt + 1;
      prev_push_cyc  <= last_push_cyc;
      prev_push_data <= last_push_data;
      last_push_cyc  <= cyc;
      last_push_data <= o_data;
    end
    if (frame_err === 1'b1) begin
      fe_cnt      <= fe_cnt + 1;
      last_fe_cyc <= cyc;
    end
    if (overrun === 1'b1) begin
      ov_cnt      <= ov_cnt + 1;
      last_ov_cyc <= cyc;
    end
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if ($countones({push === 1'b1, frame_err === 1'b1, overrun === 1'b1}) > 1 || (any && prev_any))
      viol <= viol + 1;
    prev_any <= any;
  end

  task automatic wait_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one full 8N1 frame; st is the cycle count when rx was driven low.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, output int unsigned st);
    rx = 1'b0;
    st = cyc;
    repeat (CPB) wait_clk();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) wait_clk();
    end
    rx = stop_bit;
    repeat (CPB) wait_clk();
  endtask

  initial begin
    int unsigned st, st2;
    int unsigned p0, f0, o0, b0;

    // reset state
    rst = 1'b1; rx = 1'b1; full = 1'b0;
    repeat (3) wait_clk();
    check("rst_o_data", o_data, 0);
    check("rst_push", push, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (20) wait_clk();

    // single frame 0xA5
    p0 = push_cnt; f0 = fe_cnt; o0 = ov_cnt; b0 = busy_cnt;
    send_frame(8'hA5, 1'b1, st);
    check("a5_push_count", push_cnt - p0, 1);
    check("a5_push_cycle", last_push_cyc, st + 155);
    check("a5_data", last_push_data, 8'hA5);
    check("a5_o_data_hold", o_data, 8'hA5);
    check("a5_no_fe", fe_cnt - f0, 0);
    check("a5_no_ov", ov_cnt - o0, 0);
    check("a5_busy_cycles", busy_cnt - b0, 152);
    repeat (5) wait_clk();

    // back-to-back 0x00 then 0xFF
    p0 = push_cnt; b0 = busy_cnt;
    send_frame(8'h00, 1'b1, st);
    send_frame(8'hFF, 1'b1, st2);
    check("b2b_push_count", push_cnt - p0, 2);
    check("b2b_first_data", prev_push_data, 8'h00);
    check("b2b_second_data", last_push_data, 8'hFF);
    check("b2b_first_cycle", prev_push_cyc, st + 155);
    check("b2b_spacing", last_push_cyc - prev_push_cyc, 160);
    check("b2b_busy_cycles", busy_cnt - b0, 304);
    repeat (5) wait_clk();

    // 4-cycle start glitch
    p0 = push_cnt; f0 = fe_cnt; o0 = ov_cnt; b0 = busy_cnt;
    rx = 1'b0;
    repeat (4) wait_clk();
    rx = 1'b1;
    repeat (40) wait_clk();
    check("glitch_busy_cycles", busy_cnt - b0, 8);
    check("glitch_no_push", push_cnt - p0, 0);
    check("glitch_no_fe", fe_cnt - f0, 0);
    check("glitch_no_ov", ov_cnt - o0, 0);

    // framing error on 0x3C, then early edge ignored, then 0x5A
    p0 = push_cnt; f0 = fe_cnt; b0 = busy_cnt;
    send_frame(8'h3C, 1'b0, st);
    repeat (40) wait_clk();
    rx = 1'b1;
    check("fe_count", fe_cnt - f0, 1);
    check("fe_cycle", last_fe_cyc, st + 155);
    check("fe_no_push", push_cnt - p0, 0);
    check("fe_o_data_hold", o_data, 8'hFF);
    b0 = busy_cnt;
    repeat (8) wait_clk();
    rx = 1'b0;
    repeat (3) wait_clk();
    rx = 1'b1;
    repeat (30) wait_clk();
    check("early_edge_ignored", busy_cnt - b0, 0);
    p0 = push_cnt;
    send_frame(8'h5A, 1'b1, st);
    check("after_fe_push_count", push_cnt - p0, 1);
    check("after_fe_data", last_push_data, 8'h5A);
    check("after_fe_cycle", last_push_cyc, st + 155);
    repeat (5) wait_clk();

    // overrun with full held high on 0x81, then 0x7E
    p0 = push_cnt; o0 = ov_cnt;
    full = 1'b1;
    send_frame(8'h81, 1'b1, st);
    full = 1'b0;
    check("ov_count", ov_cnt - o0, 1);
    check("ov_cycle", last_ov_cyc, st + 155);
    check("ov_no_push", push_cnt - p0, 0);
    check("ov_o_data_hold", o_data, 8'h5A);
    repeat (5) wait_clk();
    send_frame(8'h7E, 1'b1, st);
    check("post_ov_push_count", push_cnt - p0, 1);
    check("post_ov_data", last_push_data, 8'h7E);
    repeat (5) wait_clk();

    // reset during data bit 3 of 0xC3
    p0 = push_cnt; f0 = fe_cnt; o0 = ov_cnt;
    rx = 1'b0;
    repeat (CPB) wait_clk();
    for (int i = 0; i < 3; i++) begin
      rx = (8'hC3 >> i) & 8'h01;
      repeat (CPB) wait_clk();
    end
    rx = 1'b0;
    repeat (8) wait_clk();
    rst = 1'b1;
    wait_clk();
    check("midrst_o_data", o_data, 0);
    check("midrst_push", push, 0);
    check("midrst_busy", busy, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_overrun", overrun, 0);
    rst = 1'b0;
    rx = 1'b1;
    repeat (200) wait_clk();
    check("midrst_no_push", push_cnt - p0, 0);
    check("midrst_no_fe", fe_cnt - f0, 0);
    check("midrst_no_ov", ov_cnt - o0, 0);
    send_frame(8'h96, 1'b1, st);
    check("post_rst_push_count", push_cnt - p0, 1);
    check("post_rst_data", last_push_data, 8'h96);
    check("post_rst_cycle", last_push_cyc, st + 155);
    repeat (5) wait_clk();

    check("pulse_rules", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_push.md
Name: uart_rx_push

Overview:
- UART receiver sitting directly upstream of the receive FIFO; it is the "Rx" side of the Rx -> FIFO -> CTRL path.
- Oversamples the serial rx line using the system clock and deserialises 8N1 frames, LSB first.
- Delivers each good byte to the FIFO as a one-cycle push with data valid in the same cycle, since the FIFO writes while push is high.
- Reports framing errors and overruns (FIFO full at byte completion) as one-cycle pulses.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit (50 MHz / 115200); minimum 4; the bench uses 16.
- DATA_WIDTH, 8, data bits per frame; matches the FIFO DATA_WIDTH.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- full  input  1  FIFO full indication, driven by CTRL glue as count == depth.
- o_data  output  DATA_WIDTH  last good byte received; valid whenever push = 1.
- push  output  1  one-cycle write strobe to the FIFO.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- overrun  output  1  one-cycle pulse when a good byte completes while full = 1.
- busy  output  1  high in the START, DATA and STOP states.

Behaviour:
- Clocking and reset: one clock domain; reset is synchronous and active-high.
- Reset values: o_data = 0, push = 0, frame_err = 0, overrun = 0, busy = 0, both synchroniser flops = 1, state = WAIT_IDLE, cnt = 0, bit index = 0.
- Reset asserted mid-frame aborts the frame with no push and no error pulse.
- Synchroniser: rx passes through 2 flops to give rx_s; all decisions use rx_s only.
- Counter: cnt has width clog2(CLKS_PER_BIT) and is cleared on every state entry.
- HALF = (CLKS_PER_BIT-1)/2, integer division.
- WAIT_IDLE:
  - cnt increments while rx_s = 1 and clears when rx_s = 0.
  - At cnt == CLKS_PER_BIT-1 with rx_s = 1 -> IDLE.
  - Effect: CLKS_PER_BIT consecutive high samples are required before a frame can start.
  - Entered after reset and after a framing error.
- IDLE: rx_s = 0 -> START.
- START:
  - At cnt == HALF: rx_s = 0 -> DATA; rx_s = 1 -> IDLE (glitch rejected, no pulse).
- DATA:
  - At cnt == CLKS_PER_BIT-1: shift rx_s into the MSB of the shift register (right shift), clear cnt, increment bit index.
  - After DATA_WIDTH bits -> STOP.
- STOP, at cnt == CLKS_PER_BIT-1:
  - rx_s = 1 and full = 0: o_data <= shift register, push = 1 for the next cycle, -> IDLE.
  - rx_s = 1 and full = 1: overrun = 1 for one cycle, no push, o_data unchanged, -> IDLE.
  - rx_s = 0: frame_err = 1 for one cycle, no push, o_data unchanged, -> WAIT_IDLE.
- Pulse rules: push, frame_err and overrun are registered, are mutually exclusive, and are never high for two consecutive cycles.
- Latency: if t is the first clk edge at which rx is sampled low, push is high during the cycle after edge t + 3 + HALF + 9*CLKS_PER_BIT. With CLKS_PER_BIT = 16 this is t + 154.
- Back-to-back frames:
  - IDLE is entered at mid-stop, so a start edge immediately after the stop bit is accepted.
  - There is no minimum idle gap.
- The full input is evaluated only at the stop sample cycle.

Test Plan (CLKS_PER_BIT = 16):
- Reset, rx = 1 for 20 cycles, send 0xA5 8N1 at 16 clk/bit -> exactly one push at t+154, o_data = 0xA5, frame_err = 0, overrun = 0.
- Send 0x00 then 0xFF with no idle gap -> two pushes 160 cycles apart with o_data 0x00 then 0xFF; busy drops only briefly between frames.
- Drive rx low for 4 cycles only -> busy high for about 8 cycles then low; no push and no pulses.
- Send 0x3C with stop bit = 0, hold rx = 0 for 40 more cycles, then rx = 1 -> one frame_err pulse and no push. An edge before 16 consecutive high cycles is ignored; 0x5A sent afterwards is pushed correctly.
- Hold full = 1 while sending 0x81 -> one overrun pulse, no push, o_data keeps the previous value; then full = 0 and send 0x7E -> push with 0x7E.
- Assert rst for 1 cycle during data bit 3 of 0xC3 -> all outputs 0 next cycle and no pulse for the aborted frame; after 16 idle cycles, 0x96 is pushed correctly.
